// File: rtl/reg_pkg.sv
// reg_pkg: shared widths, commit entry and FSM types for the commit scheduler
package reg_pkg;
  localparam int NREGS = 8;
  localparam int AW = 3;
  localparam int ROBW = 6;
  localparam int DW = 16;
  localparam int QDEPTH = 8;
  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [ROBW-1:0] rob;
    logic [DW-1:0]   data;
  } commit_t;
  typedef enum logic {IDLE, FLUSH} state_e;
endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: 4-in/3-out circular buffer of commit entries with count, free and head view
module commit_fifo import reg_pkg::*; #(
  parameter int DEPTH = QDEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               enq_valid_i,
  input  commit_t                  enq_i [4],
  input  logic [1:0]               deq_n_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_nxt_o,
  output logic [$clog2(DEPTH):0]   free_o,
  output commit_t                  head_o [3]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  commit_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [2:0] enq_n;
  assign enq_n = 3'(enq_valid_i[0]) + 3'(enq_valid_i[1]) + 3'(enq_valid_i[2]) + 3'(enq_valid_i[3]);
  assign count_d = count_q + CW'(enq_n) - CW'(deq_n_i);
  assign count_o = count_q;
  assign count_nxt_o = count_d;
  assign free_o = CW'(DEPTH) - count_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + PW'(enq_n);
      rd_q <= rd_q + PW'(deq_n_i);
      count_q <= count_d;
    end
  end
  // lanes are contiguous from bit 0, so lane i lands at wr_q + i
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (enq_valid_i[i]) mem_q[wr_q + PW'(i)] <= enq_i[i];
  end
  always_comb begin
    for (int j = 0; j < 3; j++) head_o[j] = mem_q[rd_q + PW'(j)];
  end
endmodule

// File: rtl/reg_commit_sched.sv
// reg_commit_sched: buffers ROB commits onto three RF write ports and owns the rename busy/tag table
module reg_commit_sched import reg_pkg::*; (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             rn_wen,
  input  logic [11:0]            rn_waddr,
  input  logic [23:0]            rn_loc,
  input  logic [3:0]             cm_valid,
  input  logic [11:0]            cm_addr,
  input  logic [63:0]            cm_data,
  input  logic [23:0]            cm_rob,
  output logic                   cm_ready,
  input  logic                   flush,
  output logic                   wen0,
  output logic                   wen1,
  output logic                   wen2,
  output logic [AW-1:0]          waddr0,
  output logic [AW-1:0]          waddr1,
  output logic [AW-1:0]          waddr2,
  output logic [DW-1:0]          wdata0,
  output logic [DW-1:0]          wdata1,
  output logic [DW-1:0]          wdata2,
  output logic [NREGS-1:0]       busy_o,
  output logic [NREGS*ROBW-1:0]  loc_o,
  output logic                   flushing
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_e state_q, state_d;
  logic [NREGS-1:0] busy_q, busy_d;
  logic [ROBW-1:0] loc_q [NREGS];
  logic [ROBW-1:0] loc_d [NREGS];
  logic [2:0] wen_q;
  logic [AW-1:0] waddr_q [3];
  logic [DW-1:0] wdata_q [3];
  logic [CW-1:0] count, count_nxt, free;
  logic [1:0] deq_n;
  logic accept;
  commit_t enq [4];
  commit_t head [3];
  assign cm_ready = !reset && state_q == IDLE && free >= CW'(4);
  assign accept = cm_ready && |cm_valid;
  assign deq_n = count >= CW'(3) ? 2'd3 : count[1:0];
  always_comb begin
    for (int i = 0; i < 4; i++) enq[i] = {cm_addr[3*i +: 3], cm_rob[6*i +: 6], cm_data[16*i +: 16]};
  end
  commit_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .enq_valid_i (accept ? cm_valid : 4'b0),
    .enq_i       (enq),
    .deq_n_i     (deq_n),
    .count_o     (count),
    .count_nxt_o (count_nxt),
    .free_o      (free),
    .head_o      (head)
  );
  // drain clears come first so a same-cycle rename of the register overrides them
  always_comb begin
    state_d = state_q == IDLE ? (flush ? FLUSH : IDLE) : (count_nxt == '0 ? IDLE : FLUSH);
    busy_d = busy_q;
    loc_d = loc_q;
    for (int j = 0; j < 3; j++)
      if (deq_n > 2'(j) && busy_q[head[j].addr] && loc_q[head[j].addr] == head[j].rob)
        busy_d[head[j].addr] = 1'b0;
    if (flush) busy_d = '0;
    else if (state_q == IDLE)
      for (int i = 3; i >= 0; i--)
        if (rn_wen[i]) begin
          busy_d[rn_waddr[3*i +: 3]] = 1'b1;
          loc_d[rn_waddr[3*i +: 3]] = rn_loc[6*i +: 6];
        end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q <= '0;
      wen_q <= '0;
      for (int r = 0; r < NREGS; r++) loc_q[r] <= '0;
      for (int j = 0; j < 3; j++) begin
        waddr_q[j] <= '0;
        wdata_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q <= busy_d;
      loc_q <= loc_d;
      for (int j = 0; j < 3; j++) begin
        wen_q[j] <= deq_n > 2'(j);
        waddr_q[j] <= deq_n > 2'(j) ? head[j].addr : '0;
        wdata_q[j] <= deq_n > 2'(j) ? head[j].data : '0;
      end
    end
  end
  always_comb begin
    for (int r = 0; r < NREGS; r++) loc_o[ROBW*r +: ROBW] = loc_q[r];
  end
  assign {wen2, wen1, wen0} = wen_q;
  assign waddr0 = waddr_q[0];
  assign waddr1 = waddr_q[1];
  assign waddr2 = waddr_q[2];
  assign wdata0 = wdata_q[0];
  assign wdata1 = wdata_q[1];
  assign wdata2 = wdata_q[2];
  assign busy_o = busy_q;
  assign flushing = state_q == FLUSH;
  a_cm_contig: assert property (@(posedge clk) disable iff (reset)
    cm_valid inside {4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111});
endmodule

// File: tb/tb_reg_commit_sched.sv
// tb_reg_commit_sched: directed self-checking bench for reg_commit_sched
module tb_reg_commit_sched;
  logic clk = 0, reset = 1, flush = 0, cm_ready, flushing;
  logic [3:0] rn_wen = 0, cm_valid = 0;
  logic [11:0] rn_waddr = 0, cm_addr = 0;
  logic [23:0] rn_loc = 0, cm_rob = 0;
  logic [63:0] cm_data = 0;
  logic wen0, wen1, wen2;
  logic [2:0] waddr0, waddr1, waddr2;
  logic [15:0] wdata0, wdata1, wdata2;
  logic [7:0] busy_o;
  logic [47:0] loc_o;
  int n_cmp = 0, n_bad = 0;
  bit collect = 0;
  logic [18:0] obs [$];

  reg_commit_sched dut (
    .clk(clk), .reset(reset), .rn_wen(rn_wen), .rn_waddr(rn_waddr), .rn_loc(rn_loc),
    .cm_valid(cm_valid), .cm_addr(cm_addr), .cm_data(cm_data), .cm_rob(cm_rob),
    .cm_ready(cm_ready), .flush(flush), .wen0(wen0), .wen1(wen1), .wen2(wen2),
    .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .busy_o(busy_o), .loc_o(loc_o), .flushing(flushing)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (collect) begin
      if (wen0) obs.push_back({waddr0, wdata0});
      if (wen1) obs.push_back({waddr1, wdata1});
      if (wen2) obs.push_back({waddr2, wdata2});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lane(input int i, input int a, input int r, input int d);
    cm_addr[3*i +: 3] = 3'(a);
    cm_rob[6*i +: 6] = 6'(r);
    cm_data[16*i +: 16] = 16'(d);
  endtask

  task automatic rename_a(input int a, input int t);
    rn_wen = 4'b0001;
    rn_waddr = 12'(a);
    rn_loc = 24'(t);
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", cm_ready, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_loc", loc_o, 0);
    chk("rst_wen", {wen2, wen1, wen0}, 0);
    chk("rst_wdata0", wdata0, 0);
    chk("rst_flushing", flushing, 0);
    reset = 0;
    #1;
    chk("post_rst_ready", cm_ready, 1);

    for (int i = 0; i < 4; i++) lane(i, i + 1, i + 1, 'h11 * (i + 1));
    cm_valid = 4'hf;
    step();
    cm_valid = 0;
    chk("c4_nodrain", {wen2, wen1, wen0}, 0);
    chk("c4_ready0", cm_ready, 1);
    step();
    chk("c4_wen", {wen2, wen1, wen0}, 3'b111);
    chk("c4_addr", {waddr2, waddr1, waddr0}, {3'd3, 3'd2, 3'd1});
    chk("c4_data", {wdata2, wdata1, wdata0}, {16'h33, 16'h22, 16'h11});
    chk("c4_ready1", cm_ready, 1);
    step();
    chk("c4_wen_b", {wen2, wen1, wen0}, 3'b001);
    chk("c4_r4", {waddr0, wdata0}, {3'd4, 16'h44});
    chk("c4_ready2", cm_ready, 1);
    step();
    chk("c4_idle", {wen2, wen1, wen0}, 0);

    rename_a(5, 9);
    step();
    rn_wen = 0;
    chk("rn5_busy", busy_o[5], 1);
    chk("rn5_loc", loc_o[35:30], 9);
    lane(0, 5, 9, 'h55);
    cm_valid = 4'b0001;
    step();
    cm_valid = 0;
    chk("rn5_busy_q", busy_o[5], 1);
    step();
    chk("rn5_drain", {wen0, waddr0, wdata0}, {1'b1, 3'd5, 16'h55});
    chk("rn5_clr", busy_o[5], 0);
    chk("rn5_loc_kept", loc_o[35:30], 9);

    rn_wen = 4'b1001;
    rn_waddr = {3'd2, 3'd0, 3'd0, 3'd2};
    rn_loc = {6'd8, 6'd0, 6'd0, 6'd7};
    step();
    rn_wen = 0;
    chk("rn2_loc_a", loc_o[17:12], 7);
    chk("rn2_busy", busy_o, 8'h04);
    lane(0, 2, 8, 'h88);
    cm_valid = 4'b0001;
    step();
    cm_valid = 0;
    step();
    chk("rn2_stale_drain", {wen0, wdata0}, {1'b1, 16'h88});
    chk("rn2_stale_busy", busy_o, 8'h04);

    lane(0, 2, 7, 'h77);
    cm_valid = 4'b0001;
    step();
    cm_valid = 0;
    rename_a(2, 12);
    step();
    rn_wen = 0;
    chk("rnclr_drain", {wen0, wdata0}, {1'b1, 16'h77});
    chk("rnclr_busy", busy_o, 8'h04);
    chk("rnclr_loc", loc_o[17:12], 12);
    step();

    collect = 1;
    chk("fill_rdy0", cm_ready, 1);
    for (int i = 0; i < 4; i++) lane(i, i, 40 + i, 'h100 + i);
    cm_valid = 4'hf;
    step();
    chk("fill_rdy1", cm_ready, 1);
    for (int i = 0; i < 4; i++) lane(i, 4 + i, 44 + i, 'h104 + i);
    step();
    chk("fill_full", cm_ready, 0);
    for (int i = 0; i < 4; i++) lane(i, i, 48 + i, 'h108 + i);
    step();
    chk("fill_rdy_back", cm_ready, 1);
    step();
    cm_valid = 0;
    repeat (4) step();
    collect = 0;
    chk("fill_count", obs.size(), 12);
    for (int k = 0; k < 12 && k < obs.size(); k++)
      chk($sformatf("fill_e%0d", k), obs[k], {3'(k), 16'h100 + 16'(k)});

    lane(0, 3, 1, 'ha1);
    lane(1, 3, 2, 'ha2);
    cm_valid = 4'b0011;
    step();
    cm_valid = 0;
    step();
    chk("r3_p0", {wen0, waddr0, wdata0}, {1'b1, 3'd3, 16'ha1});
    chk("r3_p1", {wen1, waddr1, wdata1}, {1'b1, 3'd3, 16'ha2});
    chk("r3_p2", wen2, 0);

    rename_a(6, 30);
    step();
    chk("pre_fl_busy", busy_o, 8'h44);
    for (int i = 0; i < 4; i++) lane(i, i, 50 + i, 'h200 + i);
    cm_valid = 4'hf;
    rename_a(7, 20);
    step();
    for (int i = 0; i < 4; i++) lane(i, 4 + i, 54 + i, 'h204 + i);
    flush = 1;
    step();
    flush = 0;
    cm_valid = 0;
    chk("fl_flushing1", flushing, 1);
    chk("fl_busy", busy_o, 0);
    chk("fl_ready1", cm_ready, 0);
    chk("fl_drain1", {wdata2, wdata1, wdata0}, {16'h202, 16'h201, 16'h200});
    step();
    rn_wen = 0;
    chk("fl_flushing2", flushing, 1);
    chk("fl_busy2", busy_o, 0);
    chk("fl_ready2", cm_ready, 0);
    chk("fl_drain2", {wdata2, wdata1, wdata0}, {16'h205, 16'h204, 16'h203});
    step();
    chk("fl_exit", flushing, 0);
    chk("fl_ready3", cm_ready, 1);
    chk("fl_drain3", {wen2, wen1, wen0, wdata1, wdata0}, {3'b011, 16'h207, 16'h206});
    chk("fl_busy3", busy_o, 0);
    chk("fl_loc_kept", loc_o[17:12], 12);

    flush = 1;
    step();
    flush = 0;
    chk("fle_flushing", flushing, 1);
    chk("fle_ready", cm_ready, 0);
    step();
    chk("fle_exit", flushing, 0);

    for (int i = 0; i < 4; i++) lane(i, i, i, 'h300 + i);
    cm_valid = 4'hf;
    step();
    cm_valid = 0;
    reset = 1;
    step();
    chk("mid_rst_wen", {wen2, wen1, wen0}, 0);
    chk("mid_rst_ready", cm_ready, 0);
    chk("mid_rst_loc", loc_o, 0);
    reset = 0;
    step();
    chk("lost_wen", {wen2, wen1, wen0}, 0);
    chk("lost_ready", cm_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
